// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_ctrl_pkg;

    localparam int REG_AW_DEF = 4;
    localparam int R0_IDX     = 0;
    localparam int WAIT_MAX   = 255;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } hz_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// rtl/hazard_ctrl_detect.sv - combinational load-use hazard detection between ID/EX and IF/ID
module hazard_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_uses_rt,
    output logic              lu
);

    // A load into r0 produces nothing to wait for.
    assign lu = idex_mem_read
              & (idex_rt != REG_AW'(R0_IDX))
              & ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/bubble/flush sequencing; HAZARD_CTRL_PERF_EN adds perf counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic              ex_branch_taken,
    input  logic              exmem_mem_access,
    input  logic              dmem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              ex_mem_write,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              mem_timeout
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt,
    output logic [15:0]       wait_cnt
`endif
);

    hz_state_e   state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic lu;
    logic mem_stall;
    logic take_run, take_flush;
    logic pc_w_c, ifid_w_c, idex_w_c, exmem_w_c, bubble_c, ifid_fl_c, idex_fl_c;

    hazard_detect #(.REG_AW(REG_AW)) u_detect (
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .ifid_uses_rt  (ifid_uses_rt),
        .lu            (lu)
    );

    assign mem_stall = exmem_mem_access & ~dmem_ready;

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        wcnt_d     = wcnt_q;
        take_run   = 1'b0;
        take_flush = 1'b0;
        pc_w_c     = 1'b0;
        ifid_w_c   = 1'b0;
        idex_w_c   = 1'b0;
        exmem_w_c  = 1'b0;
        bubble_c   = 1'b0;
        ifid_fl_c  = 1'b0;
        idex_fl_c  = 1'b0;

        case (state_q)
            ST_RUN, ST_FLUSH: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                    wcnt_d  = 8'd1;
                end else begin
                    wcnt_d     = 8'd0;
                    take_run   = (state_q == ST_RUN);
                    take_flush = (state_q == ST_FLUSH);
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    wcnt_d = 8'd0;
                    // A flush interrupted by the wait picks up where it left off.
                    if (fcnt_q != 3'd0) take_flush = 1'b1;
                    else                take_run   = 1'b1;
                end else if (wcnt_q != 8'(WAIT_MAX)) begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (take_flush) begin
            {pc_w_c, ifid_w_c, idex_w_c, exmem_w_c} = 4'b1111;
            {ifid_fl_c, idex_fl_c}                  = 2'b11;
            if (fcnt_q <= 3'd1) begin
                state_d = ST_RUN;
                fcnt_d  = 3'd0;
            end else begin
                state_d = ST_FLUSH;
                fcnt_d  = fcnt_q - 3'd1;
            end
        end

        if (take_run) begin
            state_d = ST_RUN;
            if (ex_branch_taken) begin
                {pc_w_c, ifid_w_c, idex_w_c, exmem_w_c} = 4'b1111;
                {ifid_fl_c, idex_fl_c}                  = 2'b11;
                if (FLUSH_CYCLES > 1) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = 3'(FLUSH_CYCLES - 1);
                end
            end else if (lu) begin
                {idex_w_c, exmem_w_c, bubble_c} = 3'b111;
            end else begin
                {pc_w_c, ifid_w_c, idex_w_c, exmem_w_c} = 4'b1111;
            end
        end

        mem_timeout_d = mem_timeout_q | (wcnt_d >= 8'(MEM_TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            fcnt_q        <= 3'd0;
            wcnt_q        <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            wcnt_q        <= wcnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Reset freezes the whole pipeline regardless of state.
    assign pc_write     = pc_w_c    & ~rst;
    assign if_id_write  = ifid_w_c  & ~rst;
    assign id_ex_write  = idex_w_c  & ~rst;
    assign ex_mem_write = exmem_w_c & ~rst;
    assign id_ex_bubble = bubble_c  & ~rst;
    assign if_id_flush  = ifid_fl_c & ~rst;
    assign id_ex_flush  = idex_fl_c & ~rst;
    assign mem_timeout  = mem_timeout_q & ~rst;

`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [15:0] wait_cnt_q,  wait_cnt_d;

    always_comb begin
        stall_cnt_d = sat_inc16(stall_cnt_q, id_ex_bubble);
        flush_cnt_d = sat_inc16(flush_cnt_q, if_id_flush);
        wait_cnt_d  = sat_inc16(wait_cnt_q,  state_q == ST_MEM_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
            wait_cnt_q  <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign wait_cnt  = wait_cnt_q;
`endif

endmodule
